// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - layer sequencer driving the single-unit conv datapath and output buffer
// Optional perf counters (perf_cycles, perf_stall) are built when CONV_SEQ_PERF_EN is defined.
module conv_seq_ctrl #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int OB_AW = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             layer_sel,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             w_load,
  output logic [CH_W-1:0]  w_ch,
  input  logic             w_ready,
  output logic             conv_rst_n,
  output logic             conv_trigger,
  output logic             conv_layer,
  input  logic             conv_valid,
  input  logic [7:0]       conv_pixel,
  output logic             conv_save_done,
  output logic             ob_we,
  output logic [OB_AW-1:0] ob_addr,
  output logic [7:0]       ob_wdata,
  input  logic             ob_ready
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_RST_CONV, S_TRIG, S_WAIT_PIX, S_WRITE, S_ACK, S_DONE
  } state_t;

  localparam logic [7:0]      PIX1_LAST = 8'd181;
  localparam logic [7:0]      PIX2_LAST = 8'd131;
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(N_CH - 1);

  state_t     state;
  logic [7:0] pix;
  logic       pix_last;
  logic       start_acc;

  assign pix_last  = (pix == (conv_layer ? PIX2_LAST : PIX1_LAST));
  assign start_acc = (state == S_IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      w_load         <= 1'b0;
      w_ch           <= '0;
      conv_rst_n     <= 1'b0;
      conv_trigger   <= 1'b0;
      conv_layer     <= 1'b0;
      conv_save_done <= 1'b0;
      ob_we          <= 1'b0;
      ob_addr        <= '0;
      ob_wdata       <= '0;
      pix            <= '0;
    end else begin
      done           <= 1'b0;
      w_load         <= 1'b0;
      conv_trigger   <= 1'b0;
      conv_save_done <= 1'b0;
      conv_rst_n     <= 1'b1;
      if (state != S_IDLE && abort) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        ob_we      <= 1'b0;
        conv_rst_n <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_acc) begin
              state      <= S_LOAD_W;
              busy       <= 1'b1;
              w_load     <= 1'b1;
              w_ch       <= '0;
              pix        <= '0;
              ob_addr    <= '0;
              conv_layer <= layer_sel;
            end
          end
          // w_ready is only trusted from the cycle after the w_load pulse
          S_LOAD_W: begin
            if (!w_load && w_ready) begin
              state      <= S_RST_CONV;
              conv_rst_n <= 1'b0;
            end
          end
          S_RST_CONV: begin
            state        <= S_TRIG;
            conv_trigger <= 1'b1;
          end
          S_TRIG: state <= S_WAIT_PIX;
          S_WAIT_PIX: begin
            if (conv_valid) begin
              ob_wdata <= conv_pixel;
              ob_we    <= 1'b1;
              state    <= S_WRITE;
            end
          end
          // no save_done after a channel's last pixel: conv stays parked until reset
          S_WRITE: begin
            if (ob_ready) begin
              ob_we   <= 1'b0;
              ob_addr <= ob_addr + OB_AW'(1);
              if (!pix_last) begin
                pix            <= pix + 8'd1;
                conv_save_done <= 1'b1;
                state          <= S_ACK;
              end else if (w_ch != CH_LAST) begin
                pix    <= '0;
                w_ch   <= w_ch + CH_W'(1);
                w_load <= 1'b1;
                state  <= S_LOAD_W;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end
          S_ACK:   state <= S_WAIT_PIX;
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef CONV_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (start_acc) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy)
        perf_cycles <= perf_cycles + 32'd1;
      if (ob_we && !ob_ready)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - randomized bench for conv_seq_ctrl with conv/weight/buffer stubs and reference model
module tb_conv_seq_ctrl;
  localparam int N_CH = 4, CH_W = 2, OB_AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, start = 1'b0, layer_sel = 1'b0, abort = 1'b0;
  logic w_ready = 1'b0, conv_valid = 1'b0, ob_ready = 1'b1;
  logic [7:0] conv_pixel = 8'd0;
  logic busy, done, w_load, conv_rst_n, conv_trigger, conv_layer, conv_save_done, ob_we;
  logic [CH_W-1:0]  w_ch;
  logic [OB_AW-1:0] ob_addr;
  logic [7:0]       ob_wdata;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  conv_seq_ctrl #(.N_CH(N_CH), .CH_W(CH_W), .OB_AW(OB_AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer_sel(layer_sel), .abort(abort),
    .busy(busy), .done(done), .w_load(w_load), .w_ch(w_ch), .w_ready(w_ready),
    .conv_rst_n(conv_rst_n), .conv_trigger(conv_trigger), .conv_layer(conv_layer),
    .conv_valid(conv_valid), .conv_pixel(conv_pixel), .conv_save_done(conv_save_done),
    .ob_we(ob_we), .ob_addr(ob_addr), .ob_wdata(ob_wdata), .ob_ready(ob_ready)
`ifdef CONV_SEQ_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  int checks = 0, errors = 0, cyc = 0;

  // reference model: run progress as flags and counters, address = ch*PIX + pix
  bit m_run = 0, m_fin = 0, m_wwait = 0, m_wfirst = 0, m_rstc = 0, m_trigc = 0, m_wpix = 0, m_ack = 0;
  int m_ch = 0, m_pix = 0, m_pixn = 182;
  bit e_busy = 0, e_done = 0, e_wload = 0, e_crst = 0, e_trig = 0, e_layer = 0, e_sd = 0, e_we = 0, e_show = 1;
  int e_addr = 0, e_pc = 0, e_ps = 0;
  logic [7:0] e_wdata = 8'd0;

  // environment stubs and knobs
  int wcnt = 0, ccnt = 0, stall_left = 0;
  bit rand_ready = 0, rand_delay = 0, stray_en = 0, stall_arm = 0;

  // observations
  int n_wr, n_wload, n_crst, n_done, n_sd, n_we, last_addr, first_addr, ch1_addr;
  int t_wl, t_tr, t_we, t_sd, t_we5, t_sd5, n_we5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    n_wr = 0; n_wload = 0; n_crst = 0; n_done = 0; n_sd = 0; n_we = 0;
    last_addr = -1; first_addr = -1; ch1_addr = -1;
    t_wl = -1; t_tr = -1; t_we = -1; t_sd = -1; t_we5 = -1; t_sd5 = -1; n_we5 = 0;
  endtask

  task automatic step_model();
    e_wload = 0; e_trig = 0; e_sd = 0; e_done = 0; e_crst = 1; e_show = 0;
    if (!rst_n) begin
      {m_run, m_fin, m_wwait, m_wfirst, m_rstc, m_trigc, m_wpix, m_ack} = '0;
      m_ch = 0; m_pix = 0; e_busy = 0; e_we = 0; e_layer = 0; e_crst = 0;
      e_wdata = 8'd0; e_addr = 0; e_show = 1; e_pc = 0; e_ps = 0;
      return;
    end
    if (!m_run && start && !abort) begin
      e_pc = 0; e_ps = 0;
    end else begin
      if (e_busy) e_pc++;
      if (e_we && !ob_ready) e_ps++;
    end
    if (m_run && abort) begin
      {m_run, m_fin, m_wwait, m_wfirst, m_rstc, m_trigc, m_wpix, m_ack} = '0;
      e_busy = 0; e_we = 0; e_crst = 0;
    end else if (!m_run) begin
      if (start && !abort) begin
        m_run = 1; e_busy = 1; e_wload = 1; m_ch = 0; m_pix = 0;
        e_layer = layer_sel; m_pixn = layer_sel ? 132 : 182;
        m_wwait = 1; m_wfirst = 1;
      end
    end else if (m_fin) begin
      m_run = 0; m_fin = 0;
    end else if (m_wwait) begin
      if (!m_wfirst && w_ready) begin m_wwait = 0; e_crst = 0; m_rstc = 1; end
      m_wfirst = 0;
    end else if (m_rstc) begin
      m_rstc = 0; e_trig = 1; m_trigc = 1;
    end else if (m_trigc) begin
      m_trigc = 0; m_wpix = 1;
    end else if (m_wpix) begin
      if (conv_valid) begin m_wpix = 0; e_we = 1; e_wdata = conv_pixel; end
    end else if (e_we) begin
      if (ob_ready) begin
        e_we = 0;
        if (m_pix < m_pixn - 1) begin
          m_pix++; e_sd = 1; m_ack = 1;
        end else if (m_ch < N_CH - 1) begin
          m_ch++; m_pix = 0; e_wload = 1; m_wwait = 1; m_wfirst = 1;
        end else begin
          m_fin = 1; e_done = 1; e_busy = 0;
        end
      end
    end else if (m_ack) begin
      m_ack = 0; m_wpix = 1;
    end
    e_addr = m_ch * m_pixn + m_pix;
  endtask

  task automatic tick(input bit st, input bit ab, input bit rn);
    @(negedge clk);
    cyc++;
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("w_load", w_load, e_wload);
    chk("w_ch", w_ch, m_ch);
    chk("conv_rst_n", conv_rst_n, e_crst);
    chk("conv_trigger", conv_trigger, e_trig);
    chk("conv_layer", conv_layer, e_layer);
    chk("conv_save_done", conv_save_done, e_sd);
    chk("ob_we", ob_we, e_we);
    if (e_we || e_show) begin
      chk("ob_addr", ob_addr, e_addr);
      chk("ob_wdata", ob_wdata, e_wdata);
    end
`ifdef CONV_SEQ_PERF_EN
    chk("perf_cycles", perf_cycles, e_pc);
    chk("perf_stall", perf_stall, e_ps);
`endif
    // drive inputs for this cycle
    start = st; abort = ab; rst_n = rn;
    if (wcnt > 0) begin wcnt--; if (wcnt == 0) w_ready = 1'b1; end
    if (w_load) begin w_ready = 1'b0; wcnt = 1 + (rand_delay ? $urandom_range(2, 0) : 0); end
    conv_valid = 1'b0;
    if (ccnt > 0) begin ccnt--; if (ccnt == 0) conv_valid = 1'b1; end
    if (conv_trigger || conv_save_done) ccnt = 2 + (rand_delay ? $urandom_range(1, 0) : 0);
    if (!conv_rst_n) ccnt = 0;
    if (stray_en && m_wwait && $urandom_range(3, 0) == 0) conv_valid = 1'b1;
    conv_pixel = 8'($urandom);
    if (stall_arm && e_we && m_ch == 0 && m_pix == 5) begin stall_arm = 0; stall_left = 3; t_we5 = cyc; end
    if (stall_left > 0) begin ob_ready = 1'b0; stall_left--; end
    else ob_ready = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
    // observations of this cycle
    if (ob_we && ob_ready) begin
      n_wr++; last_addr = int'(ob_addr);
      if (first_addr < 0) first_addr = int'(ob_addr);
      if (w_ch == 2'd1 && ch1_addr < 0) ch1_addr = int'(ob_addr);
    end
    if (w_load) begin n_wload++; if (t_wl < 0) t_wl = cyc; end
    if (conv_trigger && t_tr < 0) t_tr = cyc;
    if (ob_we) begin n_we++; if (t_we < 0) t_we = cyc; end
    if (ob_we && t_we5 >= 0 && t_sd5 < 0) n_we5++;
    if (conv_save_done) begin
      n_sd++;
      if (t_sd < 0) t_sd = cyc;
      if (t_we5 >= 0 && t_sd5 < 0) t_sd5 = cyc;
    end
    if (!conv_rst_n && busy) n_crst++;
    if (done) n_done++;
    step_model();
  endtask

  // runs one layer; abort_ch < 0 means run to completion. Returns start cycle.
  task automatic run_layer(input bit lay, input int abort_ch, input int abort_pix, output int t0);
    int guard;
    bit ab, fin;
    clear_obs();
    layer_sel = lay;
    tick(1, 0, 1);
    t0 = cyc;
    guard = 0; fin = 0;
    while (!fin && guard < 20000) begin
      ab = (abort_ch >= 0) && m_wpix && m_ch == abort_ch && m_pix == abort_pix;
      tick(stray_en && m_run && $urandom_range(15, 0) == 0, ab, 1);
      if (ab || e_done) fin = 1;
      guard++;
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL run_timeout: run not finished after %0d cycles", guard);
    end
    repeat (4) tick(0, 0, 1);
  endtask

  int t0;

  initial begin
    clear_obs();
    repeat (3) tick(0, 0, 0);
    tick(0, 0, 1);
    tick(0, 0, 1);
    chk("crst_release", conv_rst_n, 1);

    // conv1, ideal handshakes: timing and totals pinned by hand
    run_layer(0, -1, 0, t0);
    chk("c1_writes", n_wr, 728);
    chk("c1_first_addr", first_addr, 0);
    chk("c1_last_addr", last_addr, 727);
    chk("c1_wload", n_wload, 4);
    chk("c1_crst_pulses", n_crst, 4);
    chk("c1_done", n_done, 1);
    chk("c1_save_done", n_sd, 724);
    chk("t_wload", t_wl - t0, 1);
    chk("t_trigger", t_tr - t0, 4);
    chk("t_first_we", t_we - t0, 7);
    chk("t_first_sd", t_sd - t0, 8);

    // conv2 with a 3-cycle buffer stall on pixel 5 of channel 0
    stall_arm = 1;
    run_layer(1, -1, 0, t0);
    chk("c2_writes", n_wr, 528);
    chk("c2_ch1_addr", ch1_addr, 132);
    chk("c2_last_addr", last_addr, 527);
    chk("c2_layer", conv_layer, 1);
    chk("c2_save_done", n_sd, 131 * 4);
    chk("stall_we_cycles", n_we5, 4);
    chk("stall_sd_delay", t_sd5 - t_we5, 4);
`ifdef CONV_SEQ_PERF_EN
    chk("perf_stall_3", perf_stall, 3);
`endif

    // randomized handshakes, stray conv_valid and repeated start while busy
    rand_ready = 1; rand_delay = 1; stray_en = 1;
    run_layer(0, -1, 0, t0);
    chk("rnd_writes", n_wr, 728);
    chk("rnd_last_addr", last_addr, 727);
    chk("rnd_done", n_done, 1);
    chk("rnd_wload", n_wload, 4);
    stray_en = 0;

    // abort in WAIT_PIX at pixel 50 of channel 2, then a clean rerun
    run_layer(0, 2, 50, t0);
    chk("abort_writes", n_wr, 2 * 182 + 50);
    chk("abort_no_done", n_done, 0);
    n_we = 0;
    repeat (8) tick(0, 0, 1);
    chk("abort_no_we", n_we, 0);
    run_layer(0, -1, 0, t0);
    chk("rerun_first_addr", first_addr, 0);
    chk("rerun_writes", n_wr, 728);
    chk("rerun_done", n_done, 1);

    // reset during RST_CONV
    rand_ready = 0; rand_delay = 0;
    clear_obs();
    layer_sel = 1'b1;
    tick(1, 0, 1);
    for (int i = 0; i < 20 && !m_rstc; i++) tick(0, 0, 1);
    tick(0, 0, 0);
    tick(0, 0, 1);
    chk("rst_busy", busy, 0);
    chk("rst_crst_low", conv_rst_n, 0);
    chk("rst_layer", conv_layer, 0);
    tick(0, 0, 1);
    chk("rst_crst_high", conv_rst_n, 1);
    repeat (4) tick(0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Sequencer for the single-unit `conv` datapath. It runs one whole convolution layer (conv1 or conv2) over `N_CH` output channels. For each channel it requests the 3x3 weight load, resets and triggers the conv unit, and captures every `valid` pixel into the output feature buffer. It returns `save_done` to `conv` only after the buffer has accepted the pixel. It sits between the top-level layer scheduler and the `conv` instance, and is the only driver of `conv`'s `rst_n`, `trigger`, `layer` and `save_done`.

## Interface
- `N_CH`, default 4: output channels per layer.
- `CH_W`, default 2: width of the channel index; N_CH <= 2^CH_W.
- `OB_AW`, default 10: output-buffer address width; must hold N_CH*182-1.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: one-cycle pulse; begin a layer run (ignored while busy).
- `layer_sel`  in  1: 0 = conv1 (16x15 in, 14x13 out), 1 = conv2 (14x13 in, 12x11 out); sampled on start.
- `abort`  in  1: level; terminate the run.
- `busy`  out  1: high from the cycle after an accepted start until done.
- `done`  out  1: one-cycle pulse at run completion.
- `w_load`  out  1: one-cycle request to the weight buffer to load channel `w_ch`.
- `w_ch`  out  CH_W: current channel index.
- `w_ready`  in  1: weights for `w_ch` stable on `conv.w_conv`.
- `conv_rst_n`  out  1: drives `conv.rst_n`.
- `conv_trigger`  out  1: drives `conv.trigger`.
- `conv_layer`  out  1: drives `conv.layer`; holds the latched layer_sel.
- `conv_valid`  in  1: `conv.valid`.
- `conv_pixel`  in  8: `conv.out_pixel`.
- `conv_save_done`  out  1: drives `conv.save_done`.
- `ob_we`  out  1: output-buffer write request.
- `ob_addr`  out  OB_AW: output-buffer address.
- `ob_wdata`  out  8: pixel data.
- `ob_ready`  in  1: buffer accepts the write on this edge when `ob_we` is high.

## Operation
- PIX = 182 for conv1 and 132 for conv2, fixed at start. A pixel counter runs 0..PIX-1 and the channel counter runs 0..N_CH-1. `ob_addr` = ch*PIX + pix, kept as a registered running counter with no multiplier.
- States and transitions:
  - IDLE: on start, go to LOAD_W.
  - LOAD_W: pulse w_load, then wait for w_ready (sampled from the cycle after w_load), then go to RST_CONV.
  - RST_CONV: hold conv_rst_n low for 1 cycle, then go to TRIG.
  - TRIG: assert conv_trigger for 1 cycle, then go to WAIT_PIX.
  - WAIT_PIX: on conv_valid, latch conv_pixel into ob_wdata and go to WRITE.
  - WRITE: hold ob_we until ob_ready.
    - Not the last pixel: go to ACK.
    - Last pixel, not the last channel: increment ch and go to LOAD_W.
    - Last pixel of the last channel: go to DONE.
  - ACK: pulse conv_save_done for 1 cycle, then go to WAIT_PIX.
  - DONE: pulse done, then go to IDLE.
- save_done is never issued after the last pixel of a channel. This parks `conv` in its wait state until the next RST_CONV.
- conv_valid seen in any state other than WAIT_PIX is a protocol error. It is ignored.
- abort in any non-IDLE state:
  - Go to IDLE next cycle with conv_rst_n low for that cycle.
  - No done pulse.
  - Any pending ob_we is dropped.
- start during busy is ignored. start and abort together in IDLE: abort wins and start is ignored.
- Reset values:
  - busy, done, w_load, conv_trigger, conv_save_done, ob_we: 0.
  - conv_rst_n: 0 (registered; rises the first cycle after rst_n goes high).
  - w_ch, ob_addr, ob_wdata, conv_layer: 0.
  - State: IDLE.
- Reset mid-run behaves like abort. The counters clear.

## Timing
- All outputs are registered.
- start at cycle 0: busy and w_load are high in cycle 1.
- With w_ready arriving in cycle 2:
  - RST_CONV in cycle 3.
  - conv_trigger in cycle 4.
  - conv_valid expected in cycle 6.
- Per pixel, with conv_valid in cycle T and ob_ready tied high:
  - ob_we in cycle T+1.
  - conv_save_done in cycle T+2.
  - Next conv_valid in cycle T+4.
  - The steady state is 4 cycles per pixel.
- Each cycle of ob_ready low extends the per-pixel period by 1. ob_we, ob_addr and ob_wdata stay stable while waiting.
- done follows the last write acceptance by 1 cycle. busy falls in the same cycle that done is high.

## Configuration
- CONV_SEQ_PERF_EN defined:
  - Adds output `perf_cycles` [31:0].
  - Counts cycles with busy high.
  - Clears on an accepted start and holds after done.
  - Reset value 0.
  - Adds output `perf_stall` [31:0], counting cycles with ob_we high and ob_ready low.
- CONV_SEQ_PERF_EN undefined: neither port exists and no counter logic is present.

## Test plan
- conv1, N_CH=4, ob_ready=1, w_ready 1 cycle after w_load -> 728 writes to addresses 0..727 in order, 4 w_load pulses (w_ch 0..3), 4 conv_rst_n low pulses, exactly 1 done; 181 save_done per channel.
- conv2, N_CH=4 -> 528 writes, ch 1 starting at ob_addr 132; conv_layer=1 throughout.
- ob_ready low for 3 cycles on pixel 5 -> ob_we, ob_addr and ob_wdata held for 4 cycles, save_done delayed by 3 cycles, no duplicate or lost write; perf_stall=3 when the macro is enabled.
- abort asserted in WAIT_PIX at pixel 50 of ch 2 -> IDLE next cycle, conv_rst_n low that cycle, no done, no further ob_we; a following start runs cleanly from addr 0.
- start pulsed again while busy, plus a stray conv_valid during LOAD_W -> both ignored; write count and addresses unchanged from the first scenario.
- rst_n low during RST_CONV -> all outputs at their reset values the next cycle; conv_rst_n released 1 cycle after rst_n rises.
